// File: rtl/servive_uart_pkg.sv
// Shared definitions for the servive UART blocks: receiver state encoding and
// frame constants.
package servive_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_rx_state_t;

    localparam int UART_DATA_BITS            = 8;
    localparam int UART_DEFAULT_CLKS_PER_BIT = 139;

endpackage

// File: rtl/servive_sync_fifo.sv
// Single-clock FIFO with extended-pointer full/empty detection. A push into a
// full FIFO is accepted when a pop frees the head slot on the same edge.
module servive_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage carries no reset; the pointers alone define what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/servive_uart_rx.sv
// 8N1 UART receiver for the SERV serial line: synchronizer, mid-bit sampling
// FSM and shift register, feeding a small output FIFO with valid/ready.
module servive_uart_rx
    import servive_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                      wb_clk,
    input  logic                      wb_rst,
    input  logic                      i_rx,
    output logic [UART_DATA_BITS-1:0] o_data,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic                      o_frame_err,
    output logic                      o_overrun
);

    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic                      sync1_q, rx_s_q, rx_d_q;
    uart_rx_state_t            state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [2:0]                idx_q, idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      push;
    logic                      ferr_d, ferr_q;
    logic                      ovr_d, ovr_q;
    logic [UART_DATA_BITS-1:0] fifo_data;
    logic                      fifo_full, fifo_empty;

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
            rx_d_q  <= 1'b1;
        end else begin
            sync1_q <= i_rx;
            rx_s_q  <= sync1_q;
            rx_d_q  <= rx_s_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        push    = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_d_q && !rx_s_q) begin
                    cnt_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == HALF) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[UART_DATA_BITS-1:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    push    = rx_s_q;
                    ferr_d  = !rx_s_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A full FIFO with the consumer ready takes the byte, so only a stalled pop drops it.
    assign ovr_d = push && fifo_full && !i_ready;

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    always_ff @(posedge wb_clk) begin
        shift_q <= shift_d;
    end

    servive_sync_fifo #(
        .WIDTH(UART_DATA_BITS),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i  (wb_clk),
        .rst_i  (wb_rst),
        .push_i (push),
        .data_i (shift_q),
        .pop_i  (i_ready),
        .data_o (fifo_data),
        .full_o (fifo_full),
        .empty_o(fifo_empty)
    );

    assign o_valid     = !fifo_empty;
    assign o_data      = fifo_empty ? '0 : fifo_data;
    assign o_frame_err = ferr_q;
    assign o_overrun   = ovr_q;

endmodule

// File: tb/tb_servive_uart_rx.sv
// Directed and randomized bench for servive_uart_rx: frames are driven bit by
// bit and checked against a queue-based model of the receive/FIFO rules.
module tb_servive_uart_rx;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;
    localparam int STOP_SAMPLE = 155;

    logic       clk = 1'b0;
    logic       wb_rst;
    logic       i_rx;
    logic [7:0] o_data;
    logic       o_valid;
    logic       i_ready;
    logic       o_frame_err;
    logic       o_overrun;

    servive_uart_rx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .wb_clk     (clk),
        .wb_rst     (wb_rst),
        .i_rx       (i_rx),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_frame_err(o_frame_err),
        .o_overrun  (o_overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observation: popped bytes, pulse counts and the cycle of the latest events.
    logic [7:0] got[$];
    int ferr_n = 0, ovr_n = 0, vbeats = 0;
    int ferr_cyc = -1, ovr_cyc = -1, vrise_cyc = -1;
    logic vld_prev = 1'b0;
    always @(negedge clk) begin
        if (o_valid && i_ready) got.push_back(o_data);
        if (o_frame_err) begin ferr_n++; ferr_cyc = cyc; end
        if (o_overrun) begin ovr_n++; ovr_cyc = cyc; end
        if (o_valid) vbeats++;
        if (o_valid && !vld_prev) vrise_cyc = cyc;
        vld_prev = o_valid;
    end

    int n_cmp = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: bytes the receiver should deliver, in order, plus flag totals.
    logic [7:0] exp_q[$];
    int m_occ = 0, exp_ferr = 0, exp_ovr = 0;
    logic ready_lvl = 1'b0;
    int cyc0 = 0;
    int got_base = 0;

    function automatic void model_frame(input logic [7:0] b, input logic stop, input logic pop_at_stop);
        logic popped;
        popped = pop_at_stop && (m_occ > 0);
        if (!stop) exp_ferr++;
        else if (m_occ < DEPTH || popped) begin
            exp_q.push_back(b);
            m_occ++;
        end else exp_ovr++;
        if (popped) m_occ--;
        if (ready_lvl) m_occ = 0;
    endfunction

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            i_rx = 1'b1; i_ready = ready_lvl; wb_rst = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int gap,
                              input int pulse_at, input int rst_at);
        for (int c = 0; c < 10 * CPB; c++) begin
            int bi;
            @(posedge clk); #1;
            if (c == 0) cyc0 = cyc;
            bi = c / CPB;
            if (bi == 0)      i_rx = 1'b0;
            else if (bi == 9) i_rx = stop;
            else              i_rx = b[bi-1];
            i_ready = (c == pulse_at) ? 1'b1 : ready_lvl;
            wb_rst  = (c == rst_at);
        end
        idle(gap);
    endtask

    task automatic frame(input logic [7:0] b, input logic stop, input int gap, input int pulse_at);
        send_frame(b, stop, gap, pulse_at, -1);
        model_frame(b, stop, pulse_at >= 0);
    endtask

    task automatic check_stream(input string tag);
        @(negedge clk);
        chk({tag, "_count"}, got.size() - got_base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (got_base + i < got.size()) chk({tag, "_byte"}, got[got_base+i], exp_q[i]);
        chk({tag, "_ferr"}, ferr_n, exp_ferr);
        chk({tag, "_ovr"}, ovr_n, exp_ovr);
        got_base = got.size();
        exp_q.delete();
    endtask

    initial begin
        int v0, c_first, c5;
        logic [7:0] rb;
        logic rs;

        wb_rst = 1'b1; i_rx = 1'b1; i_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 wb_rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", o_valid, 0);
        chk("rst_data", o_data, 8'h00);
        chk("rst_ferr", o_frame_err, 0);
        chk("rst_ovr", o_overrun, 0);
        idle(5);

        // Two back-to-back frames, consumer always ready
        ready_lvl = 1'b1;
        idle(2);
        @(negedge clk); v0 = vbeats;
        frame(8'h55, 1'b1, 0, -1);
        c_first = cyc0;
        chk("t1_vld_latency", vrise_cyc, c_first + STOP_SAMPLE);
        frame(8'hA3, 1'b1, 20, -1);
        check_stream("t1");
        chk("t1_beats", vbeats - v0, 2);

        // Short glitch on the line
        for (int k = 0; k < 5; k++) begin @(posedge clk); #1; i_rx = 1'b0; end
        idle(40);
        check_stream("t2");
        chk("t2_valid", o_valid, 0);

        // Bad stop bit, then a good frame
        ready_lvl = 1'b0;
        frame(8'h3C, 1'b0, 20, -1);
        chk("t3_ferr_latency", ferr_cyc, cyc0 + STOP_SAMPLE);
        chk("t3_valid", o_valid, 0);
        ready_lvl = 1'b1;
        frame(8'h81, 1'b1, 20, -1);
        check_stream("t3");

        // Overrun with a stalled consumer
        ready_lvl = 1'b0;
        for (int k = 1; k <= 5; k++) frame(8'(k), 1'b1, 2, -1);
        c5 = cyc0;
        chk("t4_ovr_cycle", ovr_cyc, c5 + STOP_SAMPLE);
        ready_lvl = 1'b1;
        idle(10);
        m_occ = 0;
        check_stream("t4");

        // Full FIFO with a pop on the stop-sample cycle
        ready_lvl = 1'b0;
        frame(8'h11, 1'b1, 2, -1);
        frame(8'h22, 1'b1, 2, -1);
        frame(8'h33, 1'b1, 2, -1);
        frame(8'h44, 1'b1, 2, -1);
        frame(8'h99, 1'b1, 2, STOP_SAMPLE - 1);
        ready_lvl = 1'b1;
        idle(10);
        m_occ = 0;
        check_stream("t5");

        // Reset in the middle of DATA bit 4
        send_frame(8'hF0, 1'b1, 20, -1, 5 * CPB + 8);
        @(negedge clk);
        chk("t6_valid", o_valid, 0);
        chk("t6_data", o_data, 8'h00);
        frame(8'h0F, 1'b1, 20, -1);
        check_stream("t6");

        // Random frames with occasional bad stop bits
        for (int k = 0; k < 10; k++) begin
            rb = 8'($urandom_range(0, 255));
            rs = ($urandom_range(0, 3) != 0);
            frame(rb, rs, rs ? $urandom_range(0, 3) : 20, -1);
        end
        idle(10);
        check_stream("rand");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/servive_uart_rx.md
# servive_uart_rx

Byte-level UART receiver that consumes the serial stream the SERV core bit-bangs onto `q` (8N1, LSB first) and turns it into buffered bytes with a valid/ready output. It sits directly downstream of the `servant_spi_top` instance in `servive`, on the `wb_clk` domain. It feeds the host-side consumers (the `serial_out` path, debug capture, self-checking benches) without re-sampling the raw line in each consumer.

## Interface

**Parameters**
- `CLKS_PER_BIT`, default 139: `wb_clk` cycles per UART bit (16 MHz / 115200). Must be ≥ 4.
- `FIFO_DEPTH`, default 4: output FIFO entries. Must be a power of 2 and ≥ 2.

**Ports**
- `wb_clk`  in  1: single clock; all logic on its rising edge.
- `wb_rst`  in  1: reset, synchronous, active-high.
- `i_rx`  in  1: serial line, idle high (connected to `q`).
- `o_data`  out  8: byte at the FIFO head; valid only while `o_valid`.
- `o_valid`  out  1: FIFO not empty.
- `i_ready`  in  1: consumer accepts the head byte when `o_valid && i_ready`.
- `o_frame_err`  out  1: one-cycle pulse when a stop bit samples low.
- `o_overrun`  out  1: one-cycle pulse when a good byte is dropped because the FIFO is full.

## Operation

- **Line synchronizer:** `i_rx` passes through 2 flops, giving `rx_s`. A third flop `rx_d` holds the previous `rx_s`. Synchronizer flops reset to 1.
- **FSM states:** IDLE, START, DATA, STOP. Reset state is IDLE.
- **IDLE:** on a falling edge (`rx_d==1 && rx_s==0`), load the bit counter with 0 and go to START. A line held low never retriggers.
- **START:** when the counter reaches `(CLKS_PER_BIT-1)/2`, sample `rx_s`.
  - If low, clear the counter and bit index, then go to DATA.
  - If high, treat it as a glitch and return to IDLE with no flags.
- **DATA:** when the counter reaches `CLKS_PER_BIT-1`, sample `rx_s` into the shift register (LSB first) and clear the counter. After bit index 7, go to STOP.
- **STOP:** when the counter reaches `CLKS_PER_BIT-1`, sample `rx_s`, then return to IDLE.
  - If high: push the byte into the FIFO.
  - If low: pulse `o_frame_err` and discard the byte.
- **Counter:** width `$clog2(CLKS_PER_BIT)`, no wrap beyond `CLKS_PER_BIT-1`. Bit index is 3 bits.
- **FIFO pointers:** read and write pointers are `$clog2(FIFO_DEPTH)+1` bits. Full when the MSBs differ and the low bits are equal. Empty when the pointers are equal.
- **FIFO write, normal:** accepted when not full.
- **FIFO write, full with simultaneous pop:** accepted (the pop frees the slot); no overrun.
- **FIFO write, full without pop:** the byte is dropped, `o_overrun` pulses, and FIFO contents are unchanged.
- **Pop:** `o_valid && i_ready`. `i_ready` while empty has no effect.
- **Output ordering:** `o_data` comes from the head entry; bytes leave in arrival order.

## Timing

- **Reset values:** `o_valid=0`, `o_frame_err=0`, `o_overrun=0`, `o_data=8'h00`, FIFO empty, FSM in IDLE.
- **Reset mid-frame:** the partial byte is abandoned. After reset, reception restarts only on the next falling edge.
- **Input to decision latency:** 2 cycles of synchronizer plus 1 cycle of edge detect.
  - Start sample: `(CLKS_PER_BIT-1)/2` cycles after edge detect.
  - Data/stop samples: every `CLKS_PER_BIT` cycles after that.
- **Output latency:** `o_valid` (for an empty FIFO) and `o_frame_err`/`o_overrun` assert on the cycle after the stop-bit sample edge.
- **Handshake:** after a pop, `o_data`/`o_valid` update on the next cycle. Full throughput is 1 pop per cycle.
- **Back-to-back frames:** the next start bit may begin immediately after the stop-bit midpoint. The FSM is in IDLE by then and catches that falling edge.
- **Reception vs. consumer:** reception never stalls on the consumer; backpressure only causes overrun.

## Structure

- **Shared package `servive_uart_pkg`:**
  - FSM state enum `uart_rx_state_t`, 2 bits: IDLE=0, START=1, DATA=2, STOP=3.
  - Constants `UART_DATA_BITS=8` and `UART_DEFAULT_CLKS_PER_BIT=139`.
- **Sub-module `servive_sync_fifo`:** parameterised width/depth with push/pop/full/empty, reused later for a TX path. It is natural to split it out.
- **Top level:** the synchronizer, FSM and shift register stay in `servive_uart_rx`.

## Test plan

All scenarios use `CLKS_PER_BIT=16` and `FIFO_DEPTH=4`.

1. Send `0x55` then `0xA3` back-to-back with `i_ready=1` -> `o_data` presents `0x55` then `0xA3`, one `o_valid` beat each, no error pulses.
2. Send a low pulse on `i_rx` lasting 5 cycles -> no byte, no `o_frame_err`, FSM back in IDLE.
3. Send `0x3C` with the stop bit driven low -> `o_frame_err` pulses once, `o_valid` stays 0. The line then returns high, and a following `0x81` is received correctly.
4. With `i_ready=0`, send 5 bytes `0x01`..`0x05` -> `o_overrun` pulses once (on `0x05`). Raising `i_ready` then drains exactly `0x01`..`0x04`.
5. With the FIFO holding 4 bytes, assert `i_ready` for 1 cycle exactly on the stop-sample cycle of a 5th byte `0x99` -> no overrun, and `0x99` is last in the drain order.
6. Assert `wb_rst` for 1 cycle during DATA bit 4 of `0xF0` -> outputs return to reset values, nothing is pushed, and the next frame `0x0F` is received intact.
